multi_issue_sb: RTL and testbench

MULTI_ISSUE_SB -- requirements
Module: multi_issue_sb

---
 rtl/multi_issue_sb_if.sv | 48 ++++
 rtl/multi_issue_sb.sv | 148 ++++++++++++++
 tb/tb_multi_issue_sb.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_issue_sb_if.sv
// Bundle of issue, writeback, commit and flush signals for multi_issue_sb.
// Handshake rules:
//   issue  : port k is taken when issue_valid_i[k] && issue_ready_o[k] and every
//            lower port is taken in the same cycle; a gap blocks higher ports.
//   commit : entry head+j retires when commit_valid_o[j] && commit_ack_i[j] and
//            every lower port retires in the same cycle.
//   wb     : wb_valid_i[p] is a one-cycle strobe with no back-pressure.
interface multi_issue_sb_if #(
   parameter int NR_ENTRIES      = 8,
   parameter int NR_ISSUE        = 2,
   parameter int NR_WB_PORTS     = 4,
   parameter int NR_COMMIT_PORTS = 2,
   parameter int DATA_W          = 64,
   parameter int PAYLOAD_W       = 32
);
   localparam int TID_W = $clog2(NR_ENTRIES);
   localparam int CNT_W = TID_W + 1;

   logic                                        flush_i;
   logic [NR_ISSUE-1:0]                         issue_valid_i;
   logic [NR_ISSUE-1:0][PAYLOAD_W-1:0]          issue_payload_i;
   logic [NR_ISSUE-1:0]                         issue_ready_o;
   logic [NR_ISSUE-1:0][TID_W-1:0]              issue_trans_id_o;
   logic [NR_WB_PORTS-1:0]                      wb_valid_i;
   logic [NR_WB_PORTS-1:0][TID_W-1:0]           wb_trans_id_i;
   logic [NR_WB_PORTS-1:0][DATA_W-1:0]          wb_data_i;
   logic [NR_COMMIT_PORTS-1:0]                  commit_valid_o;
   logic [NR_COMMIT_PORTS-1:0][PAYLOAD_W-1:0]   commit_payload_o;
   logic [NR_COMMIT_PORTS-1:0][DATA_W-1:0]      commit_data_o;
   logic [NR_COMMIT_PORTS-1:0][TID_W-1:0]       commit_trans_id_o;
   logic [NR_COMMIT_PORTS-1:0]                  commit_ack_i;
   logic                                        sb_full_o;
   logic [CNT_W-1:0]                            occupancy_o;

   modport slave (
      input  flush_i, issue_valid_i, issue_payload_i, wb_valid_i, wb_trans_id_i,
             wb_data_i, commit_ack_i,
      output issue_ready_o, issue_trans_id_o, commit_valid_o, commit_payload_o,
             commit_data_o, commit_trans_id_o, sb_full_o, occupancy_o
   );

   modport master (
      output flush_i, issue_valid_i, issue_payload_i, wb_valid_i, wb_trans_id_i,
             wb_data_i, commit_ack_i,
      input  issue_ready_o, issue_trans_id_o, commit_valid_o, commit_payload_o,
             commit_data_o, commit_trans_id_o, sb_full_o, occupancy_o
   );
endinterface

// File: rtl/multi_issue_sb.sv
// Multi-issue scoreboard: circular buffer of in-flight instructions that are
// issued in order, written back out of order and retired in order.
module multi_issue_sb #(
   parameter int NR_ENTRIES      = 8,
   parameter int NR_ISSUE        = 2,
   parameter int NR_WB_PORTS     = 4,
   parameter int NR_COMMIT_PORTS = 2,
   parameter int DATA_W          = 64,
   parameter int PAYLOAD_W       = 32
) (
   input logic             clk_i,
   input logic             rst_ni,
   multi_issue_sb_if.slave sb
);
   localparam int TID_W = $clog2(NR_ENTRIES);
   localparam int CNT_W = TID_W + 1;

   logic [NR_ENTRIES-1:0] valid_q;
   logic [NR_ENTRIES-1:0] done_q;
   logic [PAYLOAD_W-1:0]  payload_q [NR_ENTRIES];
   logic [DATA_W-1:0]     data_q    [NR_ENTRIES];
   logic [TID_W-1:0]      head_q;
   logic [TID_W-1:0]      tail_q;
   logic [CNT_W-1:0]      count_q;

   logic [CNT_W-1:0]                          free_cnt;
   logic [NR_ISSUE-1:0]                       issue_ready;
   logic [NR_ISSUE-1:0]                       issue_acc;
   logic [NR_ISSUE-1:0][TID_W-1:0]            issue_id;
   logic [NR_COMMIT_PORTS-1:0]                commit_valid;
   logic [NR_COMMIT_PORTS-1:0]                commit_ret;
   logic [NR_COMMIT_PORTS-1:0][TID_W-1:0]     commit_id;
   logic [CNT_W-1:0]                          n_acc;
   logic [CNT_W-1:0]                          n_ret;
   logic                                      issue_chain;
   logic                                      commit_chain;
   logic                                      ret_chain;

   // Free slots come from the registered count only, so slots retired this
   // cycle are not offered to issue until the next cycle.
   assign free_cnt = CNT_W'(NR_ENTRIES) - count_q;

   // Issue side: ready per port, IDs from tail, in-order acceptance chain.
   always_comb begin
      issue_ready = '0;
      issue_acc   = '0;
      issue_id    = '0;
      n_acc       = '0;
      issue_chain = 1'b1;
      for (int k = 0; k < NR_ISSUE; k++) begin
         issue_ready[k] = free_cnt > CNT_W'(k);
         issue_id[k]    = tail_q + TID_W'(k);
         issue_chain    = issue_chain & sb.issue_valid_i[k] & issue_ready[k];
         issue_acc[k]   = issue_chain;
         n_acc          = n_acc + CNT_W'(issue_acc[k]);
      end
   end

   // Commit side: in-order valid chain from head and the matching retire chain.
   always_comb begin
      commit_valid = '0;
      commit_ret   = '0;
      commit_id    = '0;
      n_ret        = '0;
      commit_chain = 1'b1;
      ret_chain    = 1'b1;
      for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
         commit_id[j]    = head_q + TID_W'(j);
         commit_chain    = commit_chain & valid_q[commit_id[j]] & done_q[commit_id[j]];
         commit_valid[j] = commit_chain;
         ret_chain       = ret_chain & commit_valid[j] & sb.commit_ack_i[j];
         commit_ret[j]   = ret_chain;
         n_ret           = n_ret + CNT_W'(commit_ret[j]);
      end
   end

   // Output drive; commit fields follow entry head+j whether or not it is valid.
   always_comb begin
      sb.issue_ready_o     = issue_ready;
      sb.issue_trans_id_o  = issue_id;
      sb.commit_valid_o    = commit_valid;
      sb.commit_trans_id_o = commit_id;
      sb.commit_payload_o  = '0;
      sb.commit_data_o     = '0;
      for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
         sb.commit_payload_o[j] = payload_q[commit_id[j]];
         sb.commit_data_o[j]    = data_q[commit_id[j]];
      end
      sb.sb_full_o   = (count_q == CNT_W'(NR_ENTRIES));
      sb.occupancy_o = count_q;
   end

   // Control state: writeback marks done, retire frees, issue allocates.
   // Issue targets only free slots and retire only valid ones, so they never collide.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (sb.flush_i) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (sb.wb_valid_i[p] && valid_q[sb.wb_trans_id_i[p]]) begin
               done_q[sb.wb_trans_id_i[p]] <= 1'b1;
            end
         end
         for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
            if (commit_ret[j]) begin
               valid_q[commit_id[j]] <= 1'b0;
               done_q[commit_id[j]]  <= 1'b0;
            end
         end
         for (int k = 0; k < NR_ISSUE; k++) begin
            if (issue_acc[k]) begin
               valid_q[issue_id[k]] <= 1'b1;
               done_q[issue_id[k]]  <= 1'b0;
            end
         end
         head_q  <= head_q + n_ret[TID_W-1:0];
         tail_q  <= tail_q + n_acc[TID_W-1:0];
         count_q <= count_q + n_acc - n_ret;
      end
   end

   // Payload and result storage; ascending port loop lets the highest
   // writeback port win when several target the same entry.
   always_ff @(posedge clk_i) begin
      if (!sb.flush_i) begin
         for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (sb.wb_valid_i[p] && valid_q[sb.wb_trans_id_i[p]]) begin
               data_q[sb.wb_trans_id_i[p]] <= sb.wb_data_i[p];
            end
         end
         for (int k = 0; k < NR_ISSUE; k++) begin
            if (issue_acc[k]) begin
               payload_q[issue_id[k]] <= sb.issue_payload_i[k];
            end
         end
      end
   end
endmodule

// File: tb/tb_multi_issue_sb.sv
// Self-checking bench for multi_issue_sb: directed scenarios followed by
// random traffic, all compared against an in-order queue model.
module tb_multi_issue_sb;
   localparam int NE = 8;
   localparam int NI = 2;
   localparam int NW = 4;
   localparam int NC = 2;
   localparam int DW = 64;
   localparam int PW = 32;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multi_issue_sb_if #(.NR_ENTRIES(NE), .NR_ISSUE(NI), .NR_WB_PORTS(NW),
                       .NR_COMMIT_PORTS(NC), .DATA_W(DW), .PAYLOAD_W(PW)) sb_bus ();

   multi_issue_sb #(.NR_ENTRIES(NE), .NR_ISSUE(NI), .NR_WB_PORTS(NW),
                    .NR_COMMIT_PORTS(NC), .DATA_W(DW), .PAYLOAD_W(PW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .sb     (sb_bus)
   );

   // ---------------- reference model ----------------
   // exp_q holds payloads of in-flight instructions, oldest first; the ID of
   // exp_q[i] is (m_head + i) mod NE.
   logic [PW-1:0] exp_q[$];
   int            m_head;
   bit            m_done [NE];
   logic [DW-1:0] m_data [NE];

   int checks = 0;
   int errors = 0;

   // ---------------- stimulus ----------------
   logic               s_fl;
   logic [NI-1:0]      s_iv;
   logic [NW-1:0]      s_wv;
   logic [NW-1:0][2:0] s_wid;
   logic [NW-1:0][DW-1:0] s_wd;
   logic [NC-1:0]      s_ack;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle();
      s_fl  = 1'b0;
      s_iv  = '0;
      s_wv  = '0;
      s_wid = '0;
      s_wd  = '0;
      s_ack = '0;
   endtask

   task automatic wb(input int p, input int id, input logic [DW-1:0] d);
      s_wv[p]  = 1'b1;
      s_wid[p] = 3'(id);
      s_wd[p]  = d;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_head = 0;
      for (int i = 0; i < NE; i++) m_done[i] = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 64'(sb_bus.issue_ready_o), 64'(2'b11));
      check({tag, "_cvalid"}, 64'(sb_bus.commit_valid_o), 64'(0));
      check({tag, "_full"}, 64'(sb_bus.sb_full_o), 64'(0));
      check({tag, "_occ"}, 64'(sb_bus.occupancy_o), 64'(0));
      check({tag, "_tid"}, 64'(sb_bus.issue_trans_id_o), 64'(6'b001_000));
   endtask

   // One cycle: drive at the falling edge, check outputs against the model,
   // advance the model, move to the next falling edge.
   task automatic step();
      logic [NI-1:0]      e_rdy;
      logic [NI-1:0]      e_acc;
      logic [NI-1:0][2:0] e_tid;
      logic [NC-1:0]      e_cv;
      logic [NC-1:0]      e_ret;
      logic [PW-1:0]      pl [NI];
      int size;
      int id;
      int off;
      bit chain;
      sb_bus.flush_i       = s_fl;
      sb_bus.issue_valid_i = s_iv;
      for (int k = 0; k < NI; k++) begin
         pl[k] = $urandom();
         sb_bus.issue_payload_i[k] = pl[k];
      end
      sb_bus.wb_valid_i    = s_wv;
      sb_bus.wb_trans_id_i = s_wid;
      sb_bus.wb_data_i     = s_wd;
      sb_bus.commit_ack_i  = s_ack;
      #1;
      size = exp_q.size();
      for (int k = 0; k < NI; k++) begin
         e_rdy[k] = (NE - size) > k;
         e_tid[k] = 3'((m_head + size + k) % NE);
      end
      chain = 1'b1;
      for (int j = 0; j < NC; j++) begin
         id = (m_head + j) % NE;
         chain = chain && (j < size) && m_done[id];
         e_cv[j] = chain;
      end
      check("issue_ready", 64'(sb_bus.issue_ready_o), 64'(e_rdy));
      check("issue_trans_id", 64'(sb_bus.issue_trans_id_o), 64'(e_tid));
      check("commit_valid", 64'(sb_bus.commit_valid_o), 64'(e_cv));
      check("sb_full", 64'(sb_bus.sb_full_o), 64'(size == NE));
      check("occupancy", 64'(sb_bus.occupancy_o), 64'(size));
      for (int j = 0; j < NC; j++) begin
         if (e_cv[j]) begin
            id = (m_head + j) % NE;
            check("commit_payload", 64'(sb_bus.commit_payload_o[j]), 64'(exp_q[j]));
            check("commit_data", sb_bus.commit_data_o[j], m_data[id]);
            check("commit_trans_id", 64'(sb_bus.commit_trans_id_o[j]), 64'(id));
         end
      end
      if (s_fl) begin
         model_reset();
      end else begin
         chain = 1'b1;
         for (int k = 0; k < NI; k++) begin
            chain = chain && s_iv[k] && e_rdy[k];
            e_acc[k] = chain;
         end
         chain = 1'b1;
         for (int j = 0; j < NC; j++) begin
            chain = chain && s_ack[j] && e_cv[j];
            e_ret[j] = chain;
         end
         for (int p = 0; p < NW; p++) begin
            off = (int'(s_wid[p]) - m_head + NE) % NE;
            if (s_wv[p] && off < size) begin
               m_done[s_wid[p]] = 1'b1;
               m_data[s_wid[p]] = s_wd[p];
            end
         end
         for (int j = 0; j < NC; j++) begin
            if (e_ret[j]) begin
               void'(exp_q.pop_front());
               m_done[m_head] = 1'b0;
               m_head = (m_head + 1) % NE;
            end
         end
         for (int k = 0; k < NI; k++) begin
            if (e_acc[k]) begin
               id = (m_head + exp_q.size()) % NE;
               exp_q.push_back(pl[k]);
               m_done[id] = 1'b0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic reset_mid();
      #3 rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      idle();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_flush();
      idle(); s_fl = 1'b1; step(); idle();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      idle();
      sb_bus.flush_i = 1'b0; sb_bus.issue_valid_i = '0; sb_bus.issue_payload_i = '0;
      sb_bus.wb_valid_i = '0; sb_bus.wb_trans_id_i = '0; sb_bus.wb_data_i = '0;
      sb_bus.commit_ack_i = '0;
      model_reset();
      @(negedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Dual issue, then a gapped valid vector
      s_iv = 2'b11; step(); idle();
      check("dual_occ", 64'(sb_bus.occupancy_o), 64'(2));
      s_iv = 2'b10; step(); idle();
      step();
      do_flush();

      // Out-of-order writeback
      s_iv = 2'b11; step(); s_iv = 2'b01; step(); idle();
      wb(0, 2, 64'hAAAA_0002); step(); idle();
      wb(2, 1, 64'hAAAA_0001); step(); idle();
      step();
      wb(1, 0, 64'hAAAA_0000); step(); idle();
      check("ooo_cvalid_hold", 64'(sb_bus.commit_valid_o), 64'(2'b11));
      step();
      do_flush();

      // Full and wrap
      for (int i = 0; i < 4; i++) begin s_iv = 2'b11; step(); end
      idle(); step();
      check("full_flag", 64'(sb_bus.sb_full_o), 64'(1));
      for (int i = 0; i < 4; i++) wb(i, i, 64'(100 + i));
      step(); idle();
      for (int i = 0; i < 4; i++) wb(i, i + 4, 64'(200 + i));
      step(); idle();
      s_ack = 2'b11; step(); idle();
      s_iv = 2'b11; step(); idle();
      step();
      check("wrap_occ", 64'(sb_bus.occupancy_o), 64'(8));
      do_flush();

      // Simultaneous commit and issue at count 7
      for (int i = 0; i < 3; i++) begin s_iv = 2'b11; step(); end
      s_iv = 2'b01; step(); idle();
      wb(0, 0, 64'h0707); step(); idle();
      s_ack = 2'b01; s_iv = 2'b11; step(); idle();
      check("c7_occ", 64'(sb_bus.occupancy_o), 64'(7));
      step();
      do_flush();

      // Writeback conflict and stale ID
      s_iv = 2'b11; step(); step(); s_iv = 2'b01; step(); idle();
      wb(1, 4, 64'hA0A0_A0A0); wb(3, 4, 64'hB0B0_B0B0); step(); idle();
      wb(0, 6, 64'hC0C0_C0C0); step(); idle();
      for (int i = 0; i < 4; i++) wb(i, i, 64'(300 + i));
      step(); idle();
      for (int i = 0; i < 3; i++) begin s_ack = 2'b11; step(); end
      idle(); step();

      // Flush with five valid entries and a concurrent writeback
      s_iv = 2'b11; step(); step(); s_iv = 2'b01; step(); idle();
      wb(2, 1, 64'h1111); s_fl = 1'b1; step(); idle();
      step();

      // Random traffic with a reset in the middle
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) reset_mid();
         idle();
         s_fl  = ($urandom_range(0, 199) == 0);
         s_iv  = 2'($urandom_range(0, 3));
         s_ack = 2'($urandom_range(0, 3));
         for (int p = 0; p < NW; p++) begin
            if ($urandom_range(0, 2) == 0) wb(p, $urandom_range(0, NE - 1), {$urandom(), $urandom()});
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
